spi_shift_engine: RTL

Parametrised SPI data-path shift engine, successor to the basic load/shift register. It holds one word of width DATA_LEN, transmits it serially MSB- or LSB-first, and receives a word simultaneously through separate sample and shift strobes (SPI mode 0/1 style edge split). It tracks the bit count and flags completion. It sits between the SPI clock-phase controller, which issues sample_en/shift_en, and the register/FIFO layer, which issues load_en and consumes d_out.

---
 rtl/spi_shift_engine.sv | 91 +++++++++
 1 files changed

// File: rtl/spi_shift_engine.sv
// SPI data-path shift engine: loads a word, shifts it out MSB- or LSB-first while
// shifting a word in from a separate sample flop, and pulses done on completion.
module spi_shift_engine #(
   parameter int   DATA_LEN = 8,
   parameter logic IDLE_OUT = 1'b1,
   parameter int   CNT_W    = $clog2(DATA_LEN + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_en,
   input  logic [DATA_LEN-1:0] d_in,
   input  logic                lsb_first,
   input  logic                sample_en,
   input  logic                shift_en,
   input  logic                serial_in,
   output logic                serial_out,
   output logic [DATA_LEN-1:0] d_out,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    bit_cnt
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t              state_reg;
   logic [DATA_LEN-1:0] shift_reg;
   logic [DATA_LEN-1:0] d_out_reg;
   logic [CNT_W-1:0]    bit_cnt_reg;
   logic                sample_reg;
   logic                order_reg;
   logic                done_reg;

   // A same-cycle sample bypasses the flop so sample and shift may coincide.
   logic                s_bit;
   logic [DATA_LEN-1:0] shift_next;

   assign s_bit = sample_en ? serial_in : sample_reg;

   always_comb begin
      shift_next = shift_reg;
      if (order_reg)
         shift_next = {s_bit, shift_reg[DATA_LEN-1:1]};
      else
         shift_next = {shift_reg[DATA_LEN-2:0], s_bit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         d_out_reg   <= '0;
         bit_cnt_reg <= '0;
         sample_reg  <= 1'b0;
         order_reg   <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (load_en) begin
            // Load wins over strobes and silently aborts any running transfer.
            state_reg   <= ST_ACTIVE;
            shift_reg   <= d_in;
            order_reg   <= lsb_first;
            bit_cnt_reg <= CNT_W'(DATA_LEN);
            sample_reg  <= 1'b0;
         end else if (state_reg == ST_ACTIVE) begin
            if (sample_en)
               sample_reg <= serial_in;
            if (shift_en) begin
               shift_reg <= shift_next;
               if (bit_cnt_reg != '0)
                  bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
               if (bit_cnt_reg == CNT_W'(1)) begin
                  d_out_reg <= shift_next;
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
               end
            end
         end
      end
   end

   assign busy       = (state_reg == ST_ACTIVE);
   assign done       = done_reg;
   assign d_out      = d_out_reg;
   assign bit_cnt    = bit_cnt_reg;
   assign serial_out = busy ? (order_reg ? shift_reg[0] : shift_reg[DATA_LEN-1]) : IDLE_OUT;

endmodule
